// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: packs one field-level instruction per handshake into the
// decoder's 32-bit word layout and writes legal words to instruction memory at rising addresses.
module instr_encoder_loader #(
    parameter int         ADDR_W = 10,
    parameter logic [3:0] COND   = 4'hE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [3:0]        in_alu_op,
    input  logic              in_imm_sel,
    input  logic              in_load,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [31:0]       in_imm,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   words_written,
    output logic [7:0]        err_count
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ENC,
        WRITE,
        FULL
    } state_t;

    localparam logic [1:0] CLASS_ALU  = 2'b00;
    localparam logic [1:0] CLASS_MEM  = 2'b01;
    localparam logic [1:0] CLASS_JUMP = 2'b10;

    state_t              state_reg;
    state_t              state_next;

    logic [1:0]          class_reg;
    logic [3:0]          alu_op_reg;
    logic                imm_sel_reg;
    logic                load_reg;
    logic [3:0]          rd_reg;
    logic [3:0]          rn_reg;
    logic [3:0]          rm_reg;
    logic [31:0]         imm_reg;

    logic [31:0]         word_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W:0]     words_reg;
    logic                err_reg;
    logic [7:0]          err_count_reg;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                restart;
    logic                accept_fire;
    logic                write_done;
    logic                addr_last;

    // Field packing from the latched set; legality is decided alongside the word.
    always_comb begin
        enc_word        = '0;
        enc_legal       = 1'b1;
        enc_word[31:28] = COND;
        enc_word[27:26] = class_reg;
        case (class_reg)
            CLASS_ALU: begin
                enc_word[24:21] = alu_op_reg;
                enc_word[19:16] = rn_reg;
                enc_word[15:12] = rd_reg;
                if (imm_sel_reg) begin
                    enc_word[25]  = 1'b1;
                    enc_word[7:0] = imm_reg[7:0];
                    enc_legal     = (imm_reg[31:8] == '0);
                end else begin
                    enc_word[3:0] = rm_reg;
                end
            end
            CLASS_MEM: begin
                enc_word[25]    = ~imm_sel_reg;
                enc_word[20]    = load_reg;
                enc_word[19:16] = rn_reg;
                enc_word[15:12] = rd_reg;
                if (imm_sel_reg) begin
                    enc_word[11:0] = imm_reg[11:0];
                    enc_legal      = (imm_reg[31:12] == '0);
                end
            end
            CLASS_JUMP: begin
                // Offset must be a sign-extended 24-bit value.
                enc_word[23:0] = imm_reg[23:0];
                enc_legal      = (imm_reg[31:23] == '0) || (imm_reg[31:23] == '1);
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
    end

    assign addr_last   = (addr_reg == '1);
    assign restart     = start && ((state_reg == IDLE) || (state_reg == ACCEPT) ||
                                   (state_reg == FULL));
    assign accept_fire = (state_reg == ACCEPT) && in_valid && !start;
    assign write_done  = (state_reg == WRITE) && imem_ack;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = ACCEPT;
            end
            ACCEPT: begin
                if (start)         state_next = ACCEPT;
                else if (in_valid) state_next = ENC;
            end
            ENC: begin
                state_next = enc_legal ? WRITE : ACCEPT;
            end
            WRITE: begin
                if (imem_ack) state_next = addr_last ? FULL : ACCEPT;
            end
            FULL: begin
                if (start) state_next = ACCEPT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            class_reg     <= '0;
            alu_op_reg    <= '0;
            imm_sel_reg   <= 1'b0;
            load_reg      <= 1'b0;
            rd_reg        <= '0;
            rn_reg        <= '0;
            rm_reg        <= '0;
            imm_reg       <= '0;
            word_reg      <= '0;
            addr_reg      <= '0;
            words_reg     <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (restart) begin
                addr_reg      <= base_addr;
                words_reg     <= '0;
                err_reg       <= 1'b0;
                err_count_reg <= '0;
            end
            if (accept_fire) begin
                class_reg   <= in_class;
                alu_op_reg  <= in_alu_op;
                imm_sel_reg <= in_imm_sel;
                load_reg    <= in_load;
                rd_reg      <= in_rd;
                rn_reg      <= in_rn;
                rm_reg      <= in_rm;
                imm_reg     <= in_imm;
            end
            if (state_reg == ENC) begin
                if (enc_legal) begin
                    word_reg <= enc_word;
                end else begin
                    err_reg <= 1'b1;
                    if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
                end
            end
            // The address parks on the last slot once full; there is no wrap.
            if (write_done) begin
                words_reg <= words_reg + (ADDR_W + 1)'(1);
                if (!addr_last) addr_reg <= addr_reg + ADDR_W'(1);
            end
        end
    end

    assign in_ready      = (state_reg == ACCEPT);
    assign imem_req      = (state_reg == WRITE);
    assign imem_addr     = addr_reg;
    assign imem_wdata    = word_reg;
    assign busy          = (state_reg == ENC) || (state_reg == WRITE);
    assign full          = (state_reg == FULL);
    assign err           = err_reg;
    assign words_written = words_reg;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: random field sets against a value-level model,
// with a negedge monitor that also acts as the instruction-memory responder.
module tb_instr_encoder_loader;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_class = '0;
    logic [3:0]    in_alu_op = '0;
    logic          in_imm_sel = 1'b0;
    logic          in_load = 1'b0;
    logic [3:0]    in_rd = '0;
    logic [3:0]    in_rn = '0;
    logic [3:0]    in_rm = '0;
    logic [31:0]   in_imm = '0;
    logic          imem_req;
    logic          imem_ack = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          full;
    logic          err;
    logic [AW:0]   words_written;
    logic [7:0]    err_count;

    instr_encoder_loader #(.ADDR_W(AW), .COND(4'hE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_alu_op(in_alu_op), .in_imm_sel(in_imm_sel), .in_load(in_load),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .full(full), .err(err),
        .words_written(words_written), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // model state
    int   m_addr = 0;
    int   m_words = 0;
    int   m_err = 0;
    int   m_errc = 0;
    int   m_full = 0;

    // responder controls
    int   ack_lo = 0;
    int   ack_hi = 0;
    int   ack_hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference encoding written from the field rules with plain arithmetic.
    function automatic void model_encode(input int cls, input int op, input int sel,
                                         input int ld, input int rd, input int rn,
                                         input int rm, input logic [31:0] imm,
                                         output bit ok, output logic [31:0] w);
        longint simm;
        simm = longint'($signed(imm));
        w  = 32'hE000_0000 + 32'(cls) * 32'h0400_0000;
        ok = 1'b1;
        case (cls)
            0: begin
                w = w + 32'(op) * 32'h0020_0000 + 32'(rn) * 32'h1_0000 + 32'(rd) * 32'h1000;
                if (sel != 0) begin
                    ok = (imm <= 32'd255);
                    w  = w + 32'h0200_0000 + (imm % 256);
                end else begin
                    w = w + 32'(rm);
                end
            end
            1: begin
                w = w + 32'(ld) * 32'h10_0000 + 32'(rn) * 32'h1_0000 + 32'(rd) * 32'h1000;
                if (sel != 0) begin
                    ok = (imm <= 32'd4095);
                    w  = w + (imm % 4096);
                end else begin
                    w = w + 32'h0200_0000;
                end
            end
            2: begin
                ok = (simm >= -64'sd8388608) && (simm <= 64'sd8388607);
                w  = w + (imm % 32'h0100_0000);
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Monitor + memory responder: checks each presented write against the scoreboard head.
    int req_cnt = 0;
    int ack_target = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr=%0d data=0x%08h expected no request",
                             imem_addr, imem_wdata);
                    imem_ack = 1'b1;
                end else begin
                    if (req_cnt == 0) begin
                        chk("req_latency", 32'(cyc), 32'(exp_q[0].cyc + 2));
                        ack_target = $urandom_range(ack_hi, ack_lo);
                    end
                    chk("imem_addr", 32'(imem_addr), 32'(exp_q[0].addr));
                    chk("imem_wdata", imem_wdata, exp_q[0].data);
                    if (ack_hold == 0 && req_cnt >= ack_target) begin
                        imem_ack = 1'b1;
                        void'(exp_q.pop_front());
                        $display("[TB] write addr=%0d data=0x%08h after %0d wait cycles",
                                 imem_addr, imem_wdata, req_cnt);
                        req_cnt = 0;
                    end else begin
                        imem_ack = 1'b0;
                        req_cnt++;
                    end
                end
            end else begin
                imem_ack = 1'b0;
                req_cnt  = 0;
            end
        end
    end

    task automatic do_start(input int b);
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(b);
        @(negedge clk);
        start  = 1'b0;
        m_addr = b; m_words = 0; m_err = 0; m_errc = 0; m_full = 0;
    endtask

    task automatic send(input int cls, input int op, input int sel, input int ld,
                        input int rd, input int rn, input int rm, input logic [31:0] imm,
                        input bit has_exp, input logic [31:0] exp_w);
        bit          ok;
        logic [31:0] w;
        int          waited;
        exp_t        e;
        waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
        end else begin
            in_valid = 1'b1; in_class = 2'(cls); in_alu_op = 4'(op); in_imm_sel = sel[0];
            in_load = ld[0]; in_rd = 4'(rd); in_rn = 4'(rn); in_rm = 4'(rm); in_imm = imm;
            model_encode(cls, op, sel, ld, rd, rn, rm, imm, ok, w);
            $display("[TB] send class=%0d op=%0d sel=%0d ld=%0d rd=%0d rn=%0d rm=%0d imm=0x%08h legal=%0d",
                     cls, op, sel, ld, rd, rn, rm, imm, ok);
            if (ok) begin
                e.addr = m_addr;
                e.data = has_exp ? exp_w : w;
                e.cyc  = cyc;
                exp_q.push_back(e);
                m_words++;
                if (m_addr == (1 << AW) - 1) m_full = 1;
                else m_addr++;
            end else begin
                m_err = 1;
                if (m_errc < 255) m_errc++;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending busy=%b expected 0 pending busy=0",
                     exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_err_count"}, 32'(err_count), 32'(m_errc));
        chk({tag, "_words"}, 32'(words_written), 32'(m_words));
        chk({tag, "_full"}, 32'(full), 32'(m_full));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_full == 0));
    endtask

    function automatic logic [31:0] pick_imm();
        logic [31:0] edges [8];
        logic [31:0] v;
        edges[0] = 32'd255;        edges[1] = 32'd256;
        edges[2] = 32'd4095;       edges[3] = 32'd4096;
        edges[4] = 32'h007F_FFFF;  edges[5] = 32'h0080_0000;
        edges[6] = 32'hFF80_0000;  edges[7] = 32'hFF7F_FFFF;
        case ($urandom_range(0, 5))
            0: v = 32'($urandom_range(0, 300));
            1: v = 32'($urandom_range(4000, 4200));
            2: begin
                v = 32'($urandom_range(0, 32'h007F_FFFF));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            3: v = edges[$urandom_range(0, 7)];
            4: v = $urandom();
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    initial begin
        int cls;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_words", 32'(words_written), 0);
        chk("rst_err_count", 32'(err_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);

        // directed encodings
        ack_lo = 0; ack_hi = 0;
        do_start(0);
        send(0, 4, 0, 0, 2, 1, 3, 32'h0, 1'b1, 32'hE081_2003);
        send(0, 4, 1, 0, 2, 1, 0, 32'h5A, 1'b1, 32'hE281_205A);
        drain();
        check_status("alu");
        send(0, 4, 1, 0, 2, 1, 0, 32'h100, 1'b0, 32'h0);
        drain();
        check_status("alu_imm_reject");
        send(1, 0, 1, 1, 5, 4, 0, 32'h123, 1'b1, 32'hE414_5123);
        send(2, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1'b1, 32'hE8FF_FFFC);
        drain();
        check_status("ldr_jump");

        do_start(0);
        send(2, 0, 0, 0, 0, 0, 0, 32'h0080_0000, 1'b0, 32'h0);
        send(3, 1, 0, 0, 1, 1, 1, 32'h0, 1'b0, 32'h0);
        drain();
        check_status("rejects");

        // start coincident with a handshake: start wins, the set is dropped
        @(negedge clk);
        start = 1'b1; base_addr = AW'(0); in_valid = 1'b1;
        in_class = 2'b00; in_imm_sel = 1'b0; in_alu_op = 4'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        m_addr = 0; m_words = 0; m_err = 0; m_errc = 0; m_full = 0;
        repeat (4) @(negedge clk);
        check_status("start_wins");

        // delayed ack and fill to the last address
        ack_lo = 3; ack_hi = 3;
        do_start(6);
        send(0, 2, 0, 0, 7, 8, 9, 32'h0, 1'b0, 32'h0);
        send(1, 0, 0, 0, 3, 4, 0, 32'h0, 1'b0, 32'h0);
        drain();
        check_status("full");
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_hold_in_ready", 32'(in_ready), 0);
        chk("full_hold_addr", 32'(imem_addr), 7);
        in_valid = 1'b0;

        // randomized traffic
        ack_lo = 0; ack_hi = 2;
        do_start($urandom_range(0, (1 << AW) - 1));
        for (int i = 0; i < 80; i++) begin
            if (m_full != 0) begin
                drain();
                check_status("rand_full");
                ack_hi = $urandom_range(0, 3);
                do_start($urandom_range(0, (1 << AW) - 1));
            end
            cls = $urandom_range(0, 9);
            cls = (cls < 4) ? 0 : (cls < 7) ? 1 : (cls < 9) ? 2 : 3;
            send(cls, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 pick_imm(), 1'b0, 32'h0);
            if (i % 16 == 15) begin
                drain();
                check_status("rand");
            end
        end
        drain();
        check_status("rand_end");

        // reset in the middle of a write: the word is lost
        ack_lo = 0; ack_hi = 0; ack_hold = 1;
        do_start(1);
        send(0, 3, 0, 0, 1, 2, 3, 32'h0, 1'b0, 32'h0);
        begin
            int waited;
            waited = 0;
            while (imem_req !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
        end
        chk("midwrite_req_before", 32'(imem_req), 1);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("midwrite_req", 32'(imem_req), 0);
        chk("midwrite_words", 32'(words_written), 0);
        chk("midwrite_busy", 32'(busy), 0);
        rst_n = 1'b1;
        ack_hold = 0;
        @(negedge clk);
        chk("midwrite_idle", 32'(in_ready), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

endmodule
